gh_spec_reg: RTL
================

Name: gh_spec_reg

Overview:
- Speculative global-history register with a checkpoint ring. It produces the `gh` vector consumed by the pc/gh index-hash stage of the branch predictor.
- Shifts in each predicted direction at prediction time and snapshots the pre-shift history per in-flight branch.
- On a branch-unit redirect, restores the snapshot and shifts in the resolved direction.
- Retirement frees checkpoints in order.

Parameters:
- GH_width, 36, global history length in bits; bit 0 is the most recent outcome.
- DEPTH, 16, checkpoint entries (power of two).
- PTR_W, 4, log2(DEPTH); width of tags.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- pred_valid  input  1  predictor issues a conditional branch this cycle
- pred_taken  input  1  predicted direction
- pred_ready  output  1  checkpoint slot available (= !full)
- pred_tag  output  PTR_W  tag assigned to the branch accepted this cycle (= wr_ptr)
- cmt_valid  input  1  oldest in-flight branch retires
- cmt_taken  input  1  resolved direction of the retiring branch
- fix_valid  input  1  mispredict redirect
- fix_tag  input  PTR_W  tag of the mispredicted branch
- fix_taken  input  1  resolved direction
- flush  input  1  pipeline flush (exception/ertn)
- gh  output  GH_width  current speculative history (registered)
- arch_gh  output  GH_width  committed history (see Optional Feature)
- ckpt_count  output  PTR_W+1  in-flight entries

Behaviour:
- Reset (async, rst=1): gh=0, arch_gh=0, wr_ptr=0, rd_ptr=0, ckpt_count=0, pred_ready=1. Checkpoint RAM contents are don't-care.
- Shift: next = {hist[GH_width-2:0], bit}.
- Accept when pred_valid & pred_ready & !fix_valid & !flush:
  - ckpt[wr_ptr] <= gh (pre-shift value).
  - gh <= shift(gh, pred_taken).
  - wr_ptr++ (wraps modulo DEPTH). pred_tag is valid combinationally in the same cycle.
- Full (ckpt_count==DEPTH): pred_ready=0; pred_valid is ignored with no state change.
- Commit when cmt_valid & ckpt_count!=0: rd_ptr++. cmt_valid with ckpt_count==0 is ignored.
- Fix (fix_valid, !flush):
  - gh <= shift(ckpt[fix_tag], fix_taken).
  - wr_ptr <= fix_tag+1. Younger entries are discarded; the fixed branch keeps its slot.
  - ckpt_count <= (fix_tag - rd_ptr mod DEPTH) + 1, minus 1 if a commit fires in the same cycle.
  - fix_tag must lie in [rd_ptr, wr_ptr); behaviour outside that range is undefined, and the bench checks it with an assertion.
- Priority: flush > fix > pred. Commit applies independently in the same cycle as fix or pred. A pred that loses to fix or flush is dropped and the upstream re-issues it.
- Pred and commit in the same cycle while full: pred is still rejected, because pred_ready is computed from the registered count.
- Latency: gh updates on the edge after the event, one cycle for all sources. No bypass.
- Flush: wr_ptr <= rd_ptr (after any same-cycle commit), ckpt_count <= 0. gh value per Optional Feature.
- Wrap: tags use PTR_W bits. Full/empty are distinguished by ckpt_count, not by pointer equality.
- Reset mid-operation: immediate return to reset values. No pending state survives.

Optional Feature:
- Macro: GH_ARCH_EN.
- Defined:
  - arch_gh is a register updated on each accepted commit: arch_gh <= shift(arch_gh, cmt_taken).
  - flush sets gh <= arch_gh, or shift(arch_gh, cmt_taken) when a commit fires in the same cycle.
- Undefined:
  - arch_gh is tied to 0.
  - flush sets gh <= 0.
  - cmt_taken is unused.

Test Plan:
- Reset, then pred (taken,1),(not,0),(taken,1) on consecutive cycles -> pred_tag 0,1,2; gh = 36'h5; ckpt_count=3.
- 16 preds without commit -> pred_ready=0 after the 16th; a 17th pred leaves gh, wr_ptr and count unchanged. One commit -> pred_ready=1 the next cycle.
- gh=0, preds 1,1,1,1 (tags 0-3), then fix_tag=1, fix_taken=0 -> gh=36'h2 (ckpt[1]=1, shifted with 0); wr_ptr=2; ckpt_count=2; next pred_tag=2.
- Same cycle: fix_valid (tag 2) and pred_valid -> pred dropped and gh from the fix. Same cycle: fix and cmt with rd_ptr=0, tag 2 -> ckpt_count=2.
- Wrap: run wr_ptr from 14 through 1 with interleaved commits, then fix_tag=15 -> restores ckpt[15] and wr_ptr=0.
- GH_ARCH_EN: commits taken,taken,not -> arch_gh=36'h6. Flush with 3 younger preds in flight -> gh=36'h6, ckpt_count=0. Without the macro, flush -> gh=0 and arch_gh stays 0.

Source files
------------

// File: rtl/gh_spec_reg.sv
// gh_spec_reg: speculative global-history register with a checkpoint ring.
// Shifts predicted directions into gh, snapshots pre-shift history per
// in-flight branch, restores on redirect and frees entries on commit.
// Optional macro GH_ARCH_EN: keeps a committed history (arch_gh) that a
// flush restores; without it arch_gh is 0 and flush clears gh.
// Ports:
//   clk, rst                : clock, async active-high reset
//   pred_valid/taken        : predicted branch in; pred_ready/pred_tag out
//   cmt_valid/taken         : oldest in-flight branch retires
//   fix_valid/tag/taken     : mispredict redirect
//   flush                   : pipeline flush
//   gh, arch_gh, ckpt_count : speculative/committed history, occupancy
module gh_spec_reg #(
  parameter int GH_width = 36,
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic                pred_taken,
  output logic                pred_ready,
  output logic [PTR_W-1:0]    pred_tag,
  input  logic                cmt_valid,
  input  logic                cmt_taken,
  input  logic                fix_valid,
  input  logic [PTR_W-1:0]    fix_tag,
  input  logic                fix_taken,
  input  logic                flush,
  output logic [GH_width-1:0] gh,
  output logic [GH_width-1:0] arch_gh,
  output logic [PTR_W:0]      ckpt_count
);

  logic [GH_width-1:0] r_gh;
  logic [GH_width-1:0] r_ckpt [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic                w_full;
  logic                w_cmt;
  logic                w_acc;
  logic [PTR_W-1:0]    w_dist;
  logic [PTR_W:0]      w_fix_count;
  logic [GH_width-1:0] w_fix_snap;
  logic [GH_width-1:0] w_fix_gh;
  logic [GH_width-1:0] w_pred_gh;
  logic [GH_width-1:0] w_flush_gh;

  // Full is taken from the registered count, so a same-cycle commit
  // never makes room for a pred.
  assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign pred_ready = !w_full;
  assign pred_tag   = r_wr_ptr;
  assign gh         = r_gh;
  assign ckpt_count = r_count;

  assign w_cmt = cmt_valid && (r_count != '0);
  assign w_acc = pred_valid && !w_full && !fix_valid && !flush;

  assign w_pred_gh  = {r_gh[GH_width-2:0], pred_taken};
  assign w_fix_snap = r_ckpt[fix_tag];
  assign w_fix_gh   = {w_fix_snap[GH_width-2:0], fix_taken};

  // Fixed branch keeps its slot; pointer difference wraps mod DEPTH.
  assign w_dist      = fix_tag - r_rd_ptr;
  assign w_fix_count = {1'b0, w_dist} + (PTR_W+1)'(1)
                     - (PTR_W+1)'(w_cmt);

`ifdef GH_ARCH_EN
  logic [GH_width-1:0] r_arch_gh;
  logic [GH_width-1:0] w_arch_nxt;

  assign w_arch_nxt = {r_arch_gh[GH_width-2:0], cmt_taken};
  assign w_flush_gh = w_cmt ? w_arch_nxt : r_arch_gh;
  assign arch_gh    = r_arch_gh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arch_gh <= '0;
    end else if (w_cmt) begin
      r_arch_gh <= w_arch_nxt;
    end
  end
`else
  logic w_unused_cmt_taken;

  assign w_unused_cmt_taken = cmt_taken;
  assign w_flush_gh = '0;
  assign arch_gh    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gh     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_cmt) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (flush) begin
        r_gh     <= w_flush_gh;
        r_wr_ptr <= r_rd_ptr + PTR_W'(w_cmt);
        r_count  <= '0;
      end else if (fix_valid) begin
        r_gh     <= w_fix_gh;
        r_wr_ptr <= fix_tag + PTR_W'(1);
        r_count  <= w_fix_count;
      end else begin
        if (w_acc) begin
          r_gh     <= w_pred_gh;
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        r_count <= r_count + (PTR_W+1)'(w_acc)
                 - (PTR_W+1)'(w_cmt);
      end
    end
  end

  // Snapshot storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_ckpt[r_wr_ptr] <= r_gh;
    end
  end

endmodule
